// File: rtl/eth_pkg.sv
// Shared constants, state type and CRC-32 byte step for the Ethernet receive framer.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } eth_state_e;

  // LSB-first CRC step over one byte, using the bit-reversed polynomial.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] rpoly;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) begin
      rpoly[i] = ETH_CRC_POLY[31-i];
    end
    c = crc ^ {24'h000000, data};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ rpoly;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 register for one byte.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_d8(crc_in, data);

endmodule

// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: strips preamble, SFD and FCS and flags bad frames.
// Define ETH_RX_FCS_CHECK_EN to build the CRC-32 frame check.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic       clk_125,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_err,
  output logic       stat_frame_ok,
  output logic       stat_frame_bad
);

  localparam logic [10:0] MAX_LEN_C = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] DLY_LEN_C = 11'd5;

  eth_state_e      state_r;
  logic [2:0]      pre_cnt_r;
  logic [10:0]     count_r;
  logic            err_r;
  logic [4:0][7:0] dl_r;
  logic            crc_bad_s;
  logic            frame_bad_s;

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc_r;
  logic [31:0] crc_next_s;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_r),
    .data    (rx_data),
    .crc_out (crc_next_s)
  );

  // CRC register: reseeded outside payload, advanced on every payload byte
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= ETH_CRC_INIT;
    end else if (state_r != ST_PAYLOAD) begin
      crc_r <= ETH_CRC_INIT;
    end else if (rx_dv) begin
      crc_r <= crc_next_s;
    end
  end

  assign crc_bad_s = (crc_r != ETH_CRC_RESIDUE);
`else
  assign crc_bad_s = 1'b0;
`endif

  // Verdict for a frame ending this cycle; count_r already includes the FCS bytes
  always_comb begin
    frame_bad_s = err_r | (count_r < MIN_LEN_C) | crc_bad_s;
  end

  // Framing FSM, five-byte FCS delay line and registered output beats
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pre_cnt_r      <= 3'd0;
      count_r        <= 11'd0;
      err_r          <= 1'b0;
      dl_r           <= '0;
      m_data         <= 8'h00;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      m_err          <= 1'b0;
      stat_frame_ok  <= 1'b0;
      stat_frame_bad <= 1'b0;
    end else begin
      m_data         <= 8'h00;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      m_err          <= 1'b0;
      stat_frame_ok  <= 1'b0;
      stat_frame_bad <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_dv && (rx_data == ETH_PREAMBLE)) begin
            state_r   <= ST_PREAMBLE;
            pre_cnt_r <= 3'd1;
          end else if (rx_dv) begin
            state_r <= ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state_r <= ST_IDLE;
          end else if (rx_data == ETH_SFD) begin
            state_r <= ST_PAYLOAD;
            count_r <= 11'd0;
            err_r   <= 1'b0;
          end else if ((rx_data == ETH_PREAMBLE) && (pre_cnt_r != 3'd7)) begin
            pre_cnt_r <= pre_cnt_r + 3'd1;
          end else begin
            state_r <= ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (!rx_dv) begin
            state_r <= ST_IDLE;
            if (count_r >= DLY_LEN_C) begin
              m_data         <= dl_r[4];
              m_valid        <= 1'b1;
              m_last         <= 1'b1;
              m_err          <= frame_bad_s;
              stat_frame_ok  <= ~frame_bad_s;
              stat_frame_bad <= frame_bad_s;
            end else begin
              stat_frame_bad <= 1'b1;
            end
          end else if (count_r == MAX_LEN_C) begin
            // Oversize: close the frame with the byte still in the delay line
            state_r        <= ST_DROP;
            m_data         <= dl_r[4];
            m_valid        <= 1'b1;
            m_last         <= 1'b1;
            m_err          <= 1'b1;
            stat_frame_bad <= 1'b1;
          end else begin
            dl_r <= {dl_r[3:0], rx_data};
            if (count_r != 11'h7FF) begin
              count_r <= count_r + 11'd1;
            end
            if (rx_er) begin
              err_r <= 1'b1;
            end
            if (count_r >= DLY_LEN_C) begin
              m_data  <= dl_r[4];
              m_valid <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!rx_dv) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/eth_rx_framer.md
ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518, max bytes after SFD including FCS.
REQ-002 SHALL have parameter MIN_FRAME_LEN, default 64, min bytes after SFD including FCS.
REQ-003 clk_125  in  1  125 MHz receive clock; sole clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rx_data  in  8  byte from RGMII RX stage.
REQ-006 rx_dv  in  1  byte valid.
REQ-007 rx_er  in  1  PHY receive error.
REQ-008 m_data  out  8  payload byte, preamble/SFD/FCS stripped.
REQ-009 m_valid  out  1  m_data valid; no backpressure.
REQ-010 m_last  out  1  last payload byte of frame.
REQ-011 m_err  out  1  frame bad; meaningful only with m_last.
REQ-012 stat_frame_ok / stat_frame_bad  out  1 each  one-cycle pulses per ended frame.

Function
REQ-013 FSM states SHALL be IDLE, PREAMBLE, PAYLOAD, DROP; all outputs registered.
REQ-014 IDLE: rx_dv=1 and rx_data=0x55 -> PREAMBLE; rx_dv=1 with any other byte -> DROP.
REQ-015 PREAMBLE: 0x55 stays (1-7 total accepted); 0xD5 -> PAYLOAD; 8th 0x55 or other byte -> DROP; rx_dv=0 -> IDLE; no stat pulse.
REQ-016 PAYLOAD SHALL push each byte into a 5-deep delay line and increment byte count (11 bits, saturating).
REQ-017 Byte k (k=0 first after SFD) SHALL appear on m_data with m_valid=1 one cycle after byte k+5 is sampled.
REQ-018 On first rx_dv=0 in PAYLOAD with count>=5: next cycle emit oldest delay-line byte with m_valid=m_last=1; -> IDLE; FCS bytes discarded.
REQ-019 On rx_dv=0 with count<5: no beats; stat_frame_bad pulses next cycle; -> IDLE.
REQ-020 m_err on last beat = (any rx_er while rx_dv=1 after SFD) OR count<MIN_FRAME_LEN OR CRC fail (REQ-027).
REQ-021 Sampling byte index MAX_FRAME_LEN (0-based) SHALL force end: emit oldest byte with m_last=m_err=1, -> DROP; result is MAX_FRAME_LEN-4 beats.
REQ-022 DROP: stay while rx_dv=1; rx_dv=0 -> IDLE.
REQ-023 stat_frame_ok/stat_frame_bad SHALL pulse coincident with m_last, per m_err; never both.
REQ-024 One idle cycle (rx_dv=0) between frames SHALL suffice; back-to-back frames lossless.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, clear count/CRC/delay line, drive all outputs 0; a frame in progress is discarded without m_last.
REQ-026 After release with rx_dv already high mid-frame: non-0x55 byte -> DROP until rx_dv=0.

Configuration
REQ-027 ETH_RX_FCS_CHECK_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over all bytes after SFD including FCS; pass iff register = 0xDEBB20E3 at end.
REQ-028 Undefined: no CRC logic; FCS still stripped; CRC term excluded from m_err.

Structure
REQ-029 Package eth_pkg SHALL hold ETH_PREAMBLE (0x55), ETH_SFD (0xD5), CRC polynomial, init, residue, FSM state enum.
REQ-030 Byte-wide CRC update SHALL be sub-module eth_crc32_d8 (combinational next-state), instantiated only under ETH_RX_FCS_CHECK_EN.

Verification
REQ-031 7x0x55, 0xD5, payload 0x00..0x3B, valid FCS -> 60 beats 0x00..0x3B, m_last on 0x3B, m_err=0, stat_frame_ok once.
REQ-032 Same frame, last FCS byte XOR 0x01 -> 60 beats, m_err=1, stat_frame_bad (macro on); m_err=0 (macro off).
REQ-033 rx_er=1 on payload byte 10, valid FCS -> m_err=1 on last beat.
REQ-034 1600 bytes after SFD -> exactly 1514 beats, m_last+m_err on beat 1514, no further beats until next preamble.
REQ-035 20-byte frame -> 16 beats, m_err=1 (runt); 3-byte frame -> no beats, stat_frame_bad pulse.
REQ-036 rst_n low at payload byte 30 -> outputs 0 that cycle, no m_last; then rx_dv held high 10 cycles without preamble -> no beats; next good frame -> as REQ-031.
